keccak_rate_padder: RTL and testbench
=====================================

Name: keccak_rate_padder

Overview:
- Parametrised successor of the 32-bit SHAKE pad-word generator.
- Accumulates 32-bit message words into one Keccak rate block and applies pad10*1 with a configurable domain-separation byte.
- Rate is selected at run time: SHAKE128 (1344 bits) or SHAKE256 (1088 bits).
- Sits between the message source and the Keccak-f permutation front end, and hands over full blocks with a full/ack handshake.

Parameters:
- IN_W, 32: input word width in bits; multiple of 8.
- MAX_RATE, 1344: widest supported rate in bits; sets the out width.
- RATE_A, 1344: rate in bits when mode=0 (SHAKE128).
- RATE_B, 1088: rate in bits when mode=1 (SHAKE256).
- DS_BYTE, 8'h1F: domain-separation byte inserted after the last message byte.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse. Latches mode, clears the buffer, arms the block.
- mode, in, 1: 0 = RATE_A, 1 = RATE_B. Sampled only on start.
- in, in, IN_W: message word. First byte is in[IN_W-1 -: 8].
- in_ready, in, 1: in is valid this cycle.
- is_last, in, 1: qualifies in_ready; marks the final word of the message.
- byte_num, in, log2(IN_W/8), here 2: number of valid bytes in the last word, 0..3. Meaningful only with is_last.
- buffer_full, out, 1: out holds a complete block awaiting f_ack.
- out, out, MAX_RATE: block. Word k occupies out[MAX_RATE-1-k*IN_W -: IN_W]. Bits beyond the active rate are 0.
- f_ack, in, 1: consumer has taken the block.
- done, out, 1: the padded final block has been acknowledged.
- busy, out, 1: armed and the message is not yet finished.

Behaviour:
- Reset, and the state entered after reset: state IDLE; buffer_full=0, done=0, busy=0, out=0, word count i=0.
- States and transitions:
  - IDLE --start--> FILL.
  - FILL --block full--> FULL.
  - FULL --f_ack--> FILL, or DONE if the block was padded.
  - DONE --start--> FILL.
- start in any state: clears out, i, buffer_full and done; latches the rate; goes to FILL on the next cycle.
  - A start pulse mid-message aborts the message silently.
- Words per block: RW = rate/IN_W (42 or 34).
- Accept condition: state==FILL && in_ready && !buffer_full.
  - in_ready in any other state is ignored; nothing is consumed.
  - The producer stalls on buffer_full.
- Accepted non-last word:
  - Written to slot i; i increments.
  - If i was RW-1: buffer_full=1 next cycle, state FULL, i wraps to 0.
- Accepted last word, via the pad-word sub-module:
  - Bytes 0..byte_num-1 come from in; byte byte_num = DS_BYTE; remaining bytes are 0.
  - Slots i+1..RW-1 are forced to 0.
  - Byte RW*IN_W/8-1 of the block (last rate byte) is ORed with 8'h80.
  - If i==RW-1, the 8'h80 lands in the same word. Example: byte_num=3 gives low byte 8'h9F.
  - The block is marked padded; buffer_full=1 the next cycle.
  - Padding always completes in the cycle the last word is accepted; no extra pad cycles.
- Exact-multiple messages:
  - The source sends a trailing is_last word with byte_num=0.
  - If the previous block just filled, that word waits until after f_ack and becomes slot 0 of a new block.
  - That new block is 0x1F000000, zeros..., 0x00000080 (mode-dependent length).
- Handshake:
  - f_ack is honoured only while buffer_full=1; ignored otherwise.
  - f_ack clears buffer_full and out the next cycle.
  - For a padded block, f_ack also sets done=1 and enters DONE.
  - f_ack and in_ready in the same cycle while full: the word is not accepted. The source holds it and it is accepted the cycle after buffer_full drops.
- Outputs:
  - busy=1 in FILL and in FULL-not-padded; 0 otherwise.
  - out is registered and stable for the whole time buffer_full is high.
- mode changes outside start have no effect.

Decomposition:
- Shared package keccak_pkg holds:
  - Rate constants SHAKE128_RATE=1344 and SHAKE256_RATE=1088.
  - DS constants: SHAKE=8'h1F, SHA3=8'h06.
  - PAD_END=8'h80.
  - The state enum IDLE/FILL/FULL/DONE.
- One sub-module, keccak_pad_word: combinational; inputs in, byte_num, ds byte, last_slot flag; output the padded word (with 8'h80 applied when last_slot). It generalises the 32-bit pad-word generator.

Test Plan:
- Test 1: reset, start mode=0, one is_last word 0x11223344 with byte_num=1.
  - Required: buffer_full next cycle; word0=0x111F0000; words 1..40=0; word41=0x00000080.
  - After f_ack: done=1.
- Test 2: mode=1, 33 full words, then is_last byte_num=3 with in=0xAABBCCDD.
  - Required: word33=0xAABBCC9F; out bits below the 1088-bit rate = 0.
- Test 3: mode=0, 42 full words, then is_last byte_num=0.
  - Required: first block = raw data, not padded, done stays 0.
  - After f_ack: second block word0=0x1F000000, word41=0x00000080; done after the second f_ack.
- Test 4: hold in_ready while buffer_full, and pulse f_ack without buffer_full.
  - Required: no word lost or duplicated; the stray f_ack is ignored.
- Test 5: start mid-message at i=10, then a new short message.
  - Required: the old data never appears; output matches Test 1 pattern.
- Test 6: assert reset asynchronously mid-FULL.
  - Required: buffer_full, out, done and busy are 0 immediately, without a clock edge.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak constants: rates, domain-separation bytes, pad terminator
// and the rate-padder state encoding.
package keccak_pkg;

    localparam int SHAKE128_RATE = 1344;
    localparam int SHAKE256_RATE = 1088;

    localparam logic [7:0] DS_SHAKE = 8'h1F;
    localparam logic [7:0] DS_SHA3  = 8'h06;
    localparam logic [7:0] PAD_END  = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL,
        DONE
    } state_t;

endpackage

// File: rtl/keccak_pad_word.sv
// Builds the final message word of a block: valid bytes, then the domain byte,
// then zeros; the pad terminator is ORed into the low byte when it is the last rate slot.
module keccak_pad_word
    import keccak_pkg::*;
#(
    parameter int IN_W = 32,
    parameter int BN_W = 2
) (
    input  logic [IN_W-1:0] in,
    input  logic [BN_W-1:0] byte_num,
    input  logic [7:0]      ds,
    input  logic            last_slot,
    output logic [IN_W-1:0] word
);

    localparam int NB = IN_W / 8;

    always_comb begin
        word = '0;
        for (int b = 0; b < NB; b++) begin
            if (BN_W'(b) < byte_num) begin
                word[IN_W-1-8*b -: 8] = in[IN_W-1-8*b -: 8];
            end else if (BN_W'(b) == byte_num) begin
                word[IN_W-1-8*b -: 8] = ds;
            end
        end
        // Single-word tail: the domain byte and terminator may share the low byte.
        if (last_slot) begin
            word[7:0] = word[7:0] | PAD_END;
        end
    end

endmodule

// File: rtl/keccak_rate_padder.sv
// Collects message words into one Keccak rate block, applies pad10*1 on the
// final word and hands full blocks to the permutation with a full/ack handshake.
module keccak_rate_padder
    import keccak_pkg::*;
#(
    parameter int         IN_W     = 32,
    parameter int         MAX_RATE = SHAKE128_RATE,
    parameter int         RATE_A   = SHAKE128_RATE,
    parameter int         RATE_B   = SHAKE256_RATE,
    parameter logic [7:0] DS_BYTE  = DS_SHAKE,
    localparam int        BN_W     = (IN_W > 8) ? $clog2(IN_W / 8) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [IN_W-1:0]     in,
    input  logic                in_ready,
    input  logic                is_last,
    input  logic [BN_W-1:0]     byte_num,
    output logic                buffer_full,
    output logic [MAX_RATE-1:0] out,
    input  logic                f_ack,
    output logic                done,
    output logic                busy
);

    localparam int              MAX_WORDS = MAX_RATE / IN_W;
    localparam int              IDX_W     = $clog2(MAX_WORDS + 1);
    localparam logic [IDX_W-1:0] RW_A     = IDX_W'(RATE_A / IN_W);
    localparam logic [IDX_W-1:0] RW_B     = IDX_W'(RATE_B / IN_W);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t              state;
    logic [IDX_W-1:0]    i;
    logic [IDX_W-1:0]    rw;
    logic                padded;
    logic                accept;
    logic                last_slot;
    logic [IN_W-1:0]     pad_word;
    logic [MAX_RATE-1:0] next_block;

    assign accept    = (state == FILL) && in_ready && !buffer_full;
    assign last_slot = (i == rw - ONE);

    keccak_pad_word #(
        .IN_W (IN_W),
        .BN_W (BN_W)
    ) u_pad_word (
        .in        (in),
        .byte_num  (byte_num),
        .ds        (DS_BYTE),
        .last_slot (last_slot),
        .word      (pad_word)
    );

    // Slots above i are already zero (cleared on start/ack), but the tail is
    // rewritten explicitly so the block never depends on that history.
    always_comb begin
        next_block = out;
        for (int k = 0; k < MAX_WORDS; k++) begin
            if (IDX_W'(k) == i) begin
                next_block[MAX_RATE-1-k*IN_W -: IN_W] = is_last ? pad_word : in;
            end else if (is_last && (IDX_W'(k) > i) && (IDX_W'(k) < rw)) begin
                next_block[MAX_RATE-1-k*IN_W -: IN_W] =
                    (IDX_W'(k) == rw - ONE) ? IN_W'(PAD_END) : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            i           <= '0;
            rw          <= RW_A;
            padded      <= 1'b0;
            buffer_full <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            out         <= '0;
        end else if (start) begin
            state       <= FILL;
            i           <= '0;
            rw          <= mode ? RW_B : RW_A;
            padded      <= 1'b0;
            buffer_full <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
            out         <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        out <= next_block;
                        if (is_last) begin
                            state       <= FULL;
                            buffer_full <= 1'b1;
                            padded      <= 1'b1;
                            busy        <= 1'b0;
                            i           <= '0;
                        end else if (last_slot) begin
                            state       <= FULL;
                            buffer_full <= 1'b1;
                            i           <= '0;
                        end else begin
                            i <= i + ONE;
                        end
                    end
                end
                FULL: begin
                    if (f_ack && buffer_full) begin
                        buffer_full <= 1'b0;
                        out         <= '0;
                        padded      <= 1'b0;
                        if (padded) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= FILL;
                            busy  <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_rate_padder.sv
// Directed bench for keccak_rate_padder with a byte-level block model checked every cycle.
`timescale 1ns/1ps
module tb_keccak_rate_padder;

    localparam int         IN_W     = 32;
    localparam int         MAX_RATE = 1344;
    localparam int         RATE_A   = 1344;
    localparam int         RATE_B   = 1088;
    localparam logic [7:0] DS       = 8'h1F;
    localparam int         NBYTES   = MAX_RATE / 8;

    logic                clk      = 1'b0;
    logic                reset    = 1'b1;
    logic                start    = 1'b0;
    logic                mode     = 1'b0;
    logic                in_ready = 1'b0;
    logic                is_last  = 1'b0;
    logic                f_ack    = 1'b0;
    logic [IN_W-1:0]     in_w     = '0;
    logic [1:0]          byte_num = '0;
    logic                buffer_full;
    logic                done;
    logic                busy;
    logic [MAX_RATE-1:0] out;

    int n_cmp = 0;
    int n_err = 0;

    keccak_rate_padder #(
        .IN_W     (IN_W),
        .MAX_RATE (MAX_RATE),
        .RATE_A   (RATE_A),
        .RATE_B   (RATE_B),
        .DS_BYTE  (DS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .in          (in_w),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .out         (out),
        .f_ack       (f_ack),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: the block as a flat byte string filled in message order.
    logic [7:0] m_bytes [0:NBYTES-1];
    int m_pos   = 0;
    int m_rate  = RATE_A / 8;
    bit m_full  = 1'b0;
    bit m_done  = 1'b0;
    bit m_pad   = 1'b0;
    bit m_armed = 1'b0;

    task automatic m_clear();
        for (int b = 0; b < NBYTES; b++) m_bytes[b] = 8'h00;
        m_pos = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_clear();
            m_full = 0; m_done = 0; m_pad = 0; m_armed = 0;
        end else if (start) begin
            m_clear();
            m_full = 0; m_done = 0; m_pad = 0; m_armed = 1;
            m_rate = (mode ? RATE_B : RATE_A) / 8;
        end else if (m_full) begin
            if (f_ack) begin
                m_clear();
                m_full = 0;
                if (m_pad) begin
                    m_done = 1; m_armed = 0; m_pad = 0;
                end
            end
        end else if (m_armed && in_ready) begin
            if (is_last) begin
                for (int b = 0; b < int'(byte_num); b++) m_bytes[m_pos+b] = in_w[31-8*b -: 8];
                m_bytes[m_pos+int'(byte_num)] = DS;
                for (int p = m_pos + int'(byte_num) + 1; p < m_rate; p++) m_bytes[p] = 8'h00;
                m_bytes[m_rate-1] = m_bytes[m_rate-1] | 8'h80;
                m_full = 1; m_pad = 1;
            end else begin
                for (int b = 0; b < 4; b++) m_bytes[m_pos+b] = in_w[31-8*b -: 8];
                m_pos = m_pos + 4;
                if (m_pos == m_rate) begin
                    m_full = 1; m_pos = 0;
                end
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [MAX_RATE-1:0] e;
        bit reported;
        for (int b = 0; b < NBYTES; b++) e[MAX_RATE-1-8*b -: 8] = m_bytes[b];
        chk1("model_buffer_full", buffer_full, m_full);
        chk1("model_done", done, m_done);
        chk1("model_busy", busy, m_armed && !(m_full && m_pad));
        n_cmp++;
        if (out !== e) begin
            n_err++;
            reported = 0;
            for (int k = 0; k < MAX_RATE / 32; k++) begin
                if (!reported && out[MAX_RATE-1-32*k -: 32] !== e[MAX_RATE-1-32*k -: 32]) begin
                    $display("FAIL model_out word %0d: got %08h want %08h at %0t", k,
                             out[MAX_RATE-1-32*k -: 32], e[MAX_RATE-1-32*k -: 32], $time);
                    reported = 1;
                end
            end
        end
    end

    function automatic logic [31:0] wd(input int k);
        return out[MAX_RATE-1-32*k -: 32];
    endfunction

    function automatic logic [31:0] pat(input int k);
        logic [31:0] v;
        v = 32'(k + 1);
        return (v * 32'h01010101) ^ 32'h5A0000C3;
    endfunction

    task automatic do_start(input logic m);
        start = 1'b1; mode = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input logic [1:0] bn);
        bit acc;
        acc = 0;
        in_w = w; is_last = last; byte_num = bn; in_ready = 1'b1;
        for (int n = 0; n < 300 && !acc; n++) begin
            acc = busy && !buffer_full;
            @(negedge clk);
        end
        in_ready = 1'b0; is_last = 1'b0;
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL send_word: word %08h not accepted within 300 cycles", w);
        end
    endtask

    task automatic wait_full(input string nm);
        int n;
        n = 0;
        while (!buffer_full && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk1(nm, buffer_full, 1'b1);
    endtask

    task automatic pulse_ack();
        f_ack = 1'b1;
        @(negedge clk);
        f_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] acc_or;
        repeat (2) @(negedge clk);
        chk1("rst_full", buffer_full, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_out", |out, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Test 1: single short message, SHAKE128
        do_start(1'b0);
        send_word(32'h11223344, 1'b1, 2'd1);
        chk1("t1_full", buffer_full, 1'b1);
        chk32("t1_w0", wd(0), 32'h111F0000);
        acc_or = '0;
        for (int k = 1; k <= 40; k++) acc_or = acc_or | wd(k);
        chk32("t1_w1_40", acc_or, 32'h0);
        chk32("t1_w41", wd(41), 32'h00000080);
        pulse_ack();
        chk1("t1_done", done, 1'b1);

        // Test 2: SHAKE256, final word lands in the last rate slot
        do_start(1'b1);
        for (int k = 0; k < 33; k++) send_word(pat(k), 1'b0, 2'd0);
        send_word(32'hAABBCCDD, 1'b1, 2'd3);
        chk1("t2_full", buffer_full, 1'b1);
        chk32("t2_w33", wd(33), 32'hAABBCC9F);
        chk1("t2_tail_zero", |out[MAX_RATE-RATE_B-1:0], 1'b0);
        pulse_ack();
        chk1("t2_done", done, 1'b1);

        // Test 3: exact multiple of the rate, trailing pad-only block
        do_start(1'b0);
        for (int k = 0; k < 42; k++) send_word(pat(k), 1'b0, 2'd0);
        wait_full("t3_full1");
        chk1("t3_done_blk1", done, 1'b0);
        chk32("t3_w0_raw", wd(0), pat(0));
        chk32("t3_w41_raw", wd(41), pat(41));
        fork
            send_word(32'h0, 1'b1, 2'd0);
            begin
                repeat (3) @(negedge clk);
                pulse_ack();
            end
        join
        wait_full("t3_full2");
        chk32("t3_b2_w0", wd(0), 32'h1F000000);
        chk32("t3_b2_w41", wd(41), 32'h00000080);
        chk1("t3_done_pre", done, 1'b0);
        pulse_ack();
        chk1("t3_done", done, 1'b1);

        // Test 4: word held across a full buffer, plus a stray ack
        do_start(1'b1);
        for (int k = 0; k < 34; k++) send_word(pat(k + 50), 1'b0, 2'd0);
        wait_full("t4_full1");
        fork
            send_word(32'hCAFEF00D, 1'b0, 2'd0);
            begin
                repeat (3) @(negedge clk);
                pulse_ack();
            end
        join
        pulse_ack();
        chk1("t4_stray_full", buffer_full, 1'b0);
        chk1("t4_stray_busy", busy, 1'b1);
        send_word(32'h12345678, 1'b1, 2'd2);
        chk32("t4_w0", wd(0), 32'hCAFEF00D);
        chk32("t4_w1", wd(1), 32'h12341F00);
        chk32("t4_w33", wd(33), 32'h00000080);
        pulse_ack();
        chk1("t4_done", done, 1'b1);

        // Test 5: restart mid-message discards the partial block
        do_start(1'b0);
        for (int k = 0; k < 10; k++) send_word(pat(k + 100), 1'b0, 2'd0);
        do_start(1'b0);
        send_word(32'h11223344, 1'b1, 2'd1);
        chk32("t5_w0", wd(0), 32'h111F0000);
        acc_or = '0;
        for (int k = 1; k <= 40; k++) acc_or = acc_or | wd(k);
        chk32("t5_w1_40", acc_or, 32'h0);
        chk32("t5_w41", wd(41), 32'h00000080);
        pulse_ack();
        chk1("t5_done", done, 1'b1);

        // Test 6: asynchronous reset while a data block is held
        do_start(1'b1);
        for (int k = 0; k < 34; k++) send_word(pat(k + 7), 1'b0, 2'd0);
        wait_full("t6_full");
        #2 reset = 1'b1;
        #1;
        chk1("t6_full", buffer_full, 1'b0);
        chk1("t6_out", |out, 1'b0);
        chk1("t6_done", done, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
